cbfp_rescale: RTL and testbench

Block-floating-point de-normalizer at the FFT output. It consumes the 16-lane normalized mantissa stream (11-bit I/Q) together with the per-block scaling factors produced by the CBFP normalization stage. Each 64-sample block (4 beats of 16 lanes) is restored to a common fixed-point scale (23-bit) by undoing the normalization shift. It is the inverse of the CBFP normalizer and sits between the last butterfly stage and the output interface.

---
 rtl/cbfp_pkg.sv | 36 +++
 rtl/scale_fifo.sv | 68 ++++++
 rtl/cbfp_rescale.sv | 189 ++++++++++++++++++
 tb/tb_cbfp_rescale.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// ---------------------------------------------------------------------------
// cbfp_pkg
// Shared constants for the CBFP normalizer and de-normalizer (cbfp_rescale),
// plus the per-lane restore shifter used by the de-normalizer.
//   DIN_WIDTH       normalized mantissa width
//   DOUT_WIDTH      restored sample width
//   SHIFT_WIDTH     scaling-factor width
//   SHIFT_TARGET    scaling factor that means unity gain
//   NUM_LANES       samples per beat (per I and Q)
//   BEATS_PER_BLOCK beats sharing one scaling factor
// ---------------------------------------------------------------------------
package cbfp_pkg;

  localparam int DIN_WIDTH       = 11;
  localparam int DOUT_WIDTH      = 23;
  localparam int SHIFT_WIDTH     = 5;
  localparam int SHIFT_TARGET    = 12;
  localparam int NUM_LANES       = 16;
  localparam int BEATS_PER_BLOCK = 4;

  // Sign-extend a mantissa to the output width, then shift it left (undo a
  // normalization gain) or arithmetic-right (floor toward -inf).
  function automatic logic signed [DOUT_WIDTH-1:0] shift_lane(
    input logic signed [DIN_WIDTH-1:0]  din,
    input logic        [SHIFT_WIDTH-1:0] amt,
    input logic                          left
  );
    logic signed [DOUT_WIDTH-1:0] ext;
    ext = DOUT_WIDTH'(din);
    if (left) begin
      return ext <<< amt;
    end
    return ext >>> amt;
  endfunction

endpackage

// File: rtl/scale_fifo.sv
// ---------------------------------------------------------------------------
// scale_fifo
// Synchronous FIFO holding per-block scaling factors.
//   clk, rstn   clock, asynchronous active-low reset
//   clr         synchronous clear (empties the queue, wins over push/pop)
//   push, din   write request and data; accepted when not full, or when full
//               and a pop happens in the same cycle
//   pop         read request; advances the head when not empty
//   dout        current head entry
//   full, empty occupancy flags
// ---------------------------------------------------------------------------
module scale_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !clr;
  // A full queue still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop) && !clr;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cbfp_rescale.sv
// ---------------------------------------------------------------------------
// cbfp_rescale
// Block-floating-point de-normalizer. Restores each block of normalized
// mantissas to a common fixed-point scale using the block's scaling factor.
//   clk, rstn            clock, asynchronous active-low reset
//   clr                  synchronous clear of FIFO, beat counter, error flags
//   scale_valid/scale_in scaling factor push for an upcoming block
//   scale_ready          scaling-factor queue not full
//   valid_in, din_R/Q    normalized beat (NUM_LANES lanes of I and Q)
//   valid_out, dout_R/Q  restored beat, two cycles after valid_in
//   err_underflow        sticky: a block started with no scale queued
//   err_overflow         sticky: a scale push was dropped while full
// ---------------------------------------------------------------------------
module cbfp_rescale #(
  parameter int DIN_WIDTH       = cbfp_pkg::DIN_WIDTH,
  parameter int DOUT_WIDTH      = cbfp_pkg::DOUT_WIDTH,
  parameter int NUM_LANES       = cbfp_pkg::NUM_LANES,
  parameter int SHIFT_WIDTH     = cbfp_pkg::SHIFT_WIDTH,
  parameter int SHIFT_TARGET    = cbfp_pkg::SHIFT_TARGET,
  parameter int BEATS_PER_BLOCK = cbfp_pkg::BEATS_PER_BLOCK,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clr,
  input  logic                         scale_valid,
  input  logic [SHIFT_WIDTH-1:0]       scale_in,
  output logic                         scale_ready,
  input  logic                         valid_in,
  input  logic signed [DIN_WIDTH-1:0]  din_R  [0:NUM_LANES-1],
  input  logic signed [DIN_WIDTH-1:0]  din_Q  [0:NUM_LANES-1],
  output logic                         valid_out,
  output logic signed [DOUT_WIDTH-1:0] dout_R [0:NUM_LANES-1],
  output logic signed [DOUT_WIDTH-1:0] dout_Q [0:NUM_LANES-1],
  output logic                         err_underflow,
  output logic                         err_overflow
);

  import cbfp_pkg::*;

  localparam int BEAT_W = (BEATS_PER_BLOCK > 1) ? $clog2(BEATS_PER_BLOCK) : 1;
  localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(BEATS_PER_BLOCK - 1);
  localparam logic [SHIFT_WIDTH-1:0] TARGET_S  = SHIFT_WIDTH'(SHIFT_TARGET);
  localparam logic [SHIFT_WIDTH-1:0] MAX_S     = SHIFT_WIDTH'(DOUT_WIDTH - 1);

  logic [BEAT_W-1:0]      beat_cnt;
  logic [SHIFT_WIDTH-1:0] blk_scale_q;
  logic                   blk_has_q;

  logic [SHIFT_WIDTH-1:0] fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic                   first_beat;
  logic                   last_beat;
  logic                   beat_go;
  logic                   push;
  logic                   pop;
  logic                   cur_has;
  logic [SHIFT_WIDTH-1:0] cur_scale;
  logic [SHIFT_WIDTH-1:0] scale_clamped;
  logic                   shift_left;
  logic [SHIFT_WIDTH-1:0] shift_amt;
  logic                   underflow_evt;
  logic                   overflow_evt;

  logic                         s1_valid;
  logic                         s1_left;
  logic [SHIFT_WIDTH-1:0]       s1_amt;
  logic signed [DIN_WIDTH-1:0]  s1_din_R [NUM_LANES];
  logic signed [DIN_WIDTH-1:0]  s1_din_Q [NUM_LANES];
  logic signed [DOUT_WIDTH-1:0] sh_R     [NUM_LANES];
  logic signed [DOUT_WIDTH-1:0] sh_Q     [NUM_LANES];

  scale_fifo #(
    .WIDTH (SHIFT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_scale_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .push  (push),
    .din   (scale_in),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign scale_ready = !fifo_full;

  always_comb begin
    first_beat    = (beat_cnt == '0);
    last_beat     = (beat_cnt == LAST_BEAT);
    beat_go       = valid_in && !clr;
    push          = scale_valid && !clr;
    cur_has       = blk_has_q;
    cur_scale     = blk_scale_q;
    // The first beat takes its scale straight from the queue head; later
    // beats reuse the latched copy.
    if (first_beat) begin
      cur_has   = !fifo_empty;
      cur_scale = fifo_empty ? TARGET_S : fifo_head;
    end
    // Only a block that actually took a scale gives it back at block end;
    // a scale pushed during an underflowed block belongs to the next one.
    pop           = beat_go && last_beat && cur_has;
    underflow_evt = beat_go && first_beat && fifo_empty;
    overflow_evt  = push && fifo_full && !pop;
    scale_clamped = (cur_scale > MAX_S) ? MAX_S : cur_scale;
    shift_left    = (scale_clamped <= TARGET_S);
    shift_amt     = shift_left ? (TARGET_S - scale_clamped)
                               : (scale_clamped - TARGET_S);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt      <= '0;
      blk_scale_q   <= TARGET_S;
      blk_has_q     <= 1'b0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else if (clr) begin
      beat_cnt      <= '0;
      blk_scale_q   <= TARGET_S;
      blk_has_q     <= 1'b0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      if (beat_go) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        if (first_beat) begin
          blk_scale_q <= cur_scale;
          blk_has_q   <= cur_has;
        end
      end
      if (underflow_evt) err_underflow <= 1'b1;
      if (overflow_evt)  err_overflow  <= 1'b1;
    end
  end

  // Stage 1: capture mantissas and the resolved shift for this beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_left  <= 1'b1;
      s1_amt   <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        s1_din_R[i] <= '0;
        s1_din_Q[i] <= '0;
      end
    end else begin
      s1_valid <= beat_go;
      if (beat_go) begin
        s1_left <= shift_left;
        s1_amt  <= shift_amt;
        for (int i = 0; i < NUM_LANES; i++) begin
          s1_din_R[i] <= din_R[i];
          s1_din_Q[i] <= din_Q[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign sh_R[g] = shift_lane(s1_din_R[g], s1_amt, s1_left);
    assign sh_Q[g] = shift_lane(s1_din_Q[g], s1_amt, s1_left);
  end

  // Stage 2: register the restored samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        dout_R[i] <= '0;
        dout_Q[i] <= '0;
      end
    end else begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          dout_R[i] <= sh_R[i];
          dout_Q[i] <= sh_Q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_cbfp_rescale.sv
module tb_cbfp_rescale;

  localparam int NL = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              clr;
  logic              scale_valid;
  logic [4:0]        scale_in;
  logic              scale_ready;
  logic              valid_in;
  logic signed [10:0] din_R  [0:NL-1];
  logic signed [10:0] din_Q  [0:NL-1];
  logic              valid_out;
  logic signed [22:0] dout_R [0:NL-1];
  logic signed [22:0] dout_Q [0:NL-1];
  logic              err_underflow;
  logic              err_overflow;

  cbfp_rescale dut (
    .clk           (clk),
    .rstn          (rstn),
    .clr           (clr),
    .scale_valid   (scale_valid),
    .scale_in      (scale_in),
    .scale_ready   (scale_ready),
    .valid_in      (valid_in),
    .din_R         (din_R),
    .din_Q         (din_Q),
    .valid_out     (valid_out),
    .dout_R        (dout_R),
    .dout_Q        (dout_Q),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard entry: expected restored beat and the cycle it must appear in.
  typedef struct {
    int     cyc;
    longint r[NL];
    longint q[NL];
  } exp_t;
  exp_t exp_q[$];

  // Reference model of the scale queue and block sequencing.
  int mq[$];
  int m_b;
  int blk_s;
  bit m_has;
  bit m_und;
  bit m_ovf;

  function automatic longint model_out(int din, int s);
    int     d;
    longint p;
    longint q;
    if (s > 22) s = 22;
    d = 12 - s;
    if (d >= 0) return longint'(din) * (longint'(1) << d);
    p = longint'(1) << (-d);
    q = longint'(din) / p;
    if ((longint'(din) % p != 0) && (din < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_b = 0; blk_s = 12; m_has = 0; m_und = 0; m_ovf = 0;
  endtask

  // Drive one cycle of stimulus (inputs sampled at the next rising edge).
  task automatic drive(input bit sv, input int s, input bit v);
    exp_t e;
    scale_valid = sv;
    scale_in    = 5'(s);
    valid_in    = v;
    if (v) begin
      if (m_b == 0) begin
        if (mq.size() == 0) begin
          m_und = 1; blk_s = 12; m_has = 0;
        end else begin
          blk_s = mq[0]; m_has = 1;
        end
      end
      e.cyc = cyc + 2;
      for (int i = 0; i < NL; i++) begin
        e.r[i] = model_out(int'(din_R[i]), blk_s);
        e.q[i] = model_out(int'(din_Q[i]), blk_s);
      end
      exp_q.push_back(e);
      if (m_b == 3 && m_has) void'(mq.pop_front());
      m_b = (m_b + 1) % 4;
    end
    if (sv) begin
      if (mq.size() < 8) mq.push_back(s);
      else m_ovf = 1;
    end
    @(posedge clk); #1;
    scale_valid = 0;
    valid_in    = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0);
  endtask

  task automatic do_clr();
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    mq.delete();
    m_b = 0; m_has = 0; m_und = 0; m_ovf = 0;
  endtask

  task automatic const_din(input int r, input int q);
    for (int i = 0; i < NL; i++) begin
      din_R[i] = 11'(r);
      din_Q[i] = 11'(q);
    end
  endtask

  task automatic rand_din();
    for (int i = 0; i < NL; i++) begin
      din_R[i] = 11'($urandom_range(0, 2047));
      din_Q[i] = 11'($urandom_range(0, 2047));
    end
  endtask

  task automatic block_rand(input int nblk);
    repeat (nblk) begin
      for (int k = 0; k < 4; k++) begin
        rand_din();
        drive(0, 0, 1);
      end
    end
  endtask

  // Output monitor: compares each restored beat against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_cycle", cyc, e.cyc);
          for (int i = 0; i < NL; i++) begin
            check($sformatf("dout_R[%0d]", i), dout_R[i], e.r[i]);
            check($sformatf("dout_Q[%0d]", i), dout_Q[i], e.q[i]);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        check("missing_valid_out", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  int pushes_a[9] = '{5, 6, 7, 8, 9, 10, 11, 12, 13};
  int pushes_b[8] = '{31, 22, 13, 12, 1, 23, 7, 17};
  int pushes_c[8] = '{10, 0, 3, 14, 20, 22, 18, 12};

  initial begin
    rstn = 0; clr = 0; scale_valid = 0; scale_in = '0; valid_in = 0;
    const_din(0, 0);
    model_reset();
    #12;
    check("rst_valid_out", valid_out, 0);
    check("rst_dout_R0", dout_R[0], 0);
    check("rst_dout_Q15", dout_Q[15], 0);
    check("rst_scale_ready", scale_ready, 1);
    check("rst_err_underflow", err_underflow, 0);
    check("rst_err_overflow", err_overflow, 0);
    @(posedge clk); #1;
    rstn = 1;

    // Unity scale block.
    const_din(100, -100);
    drive(1, 12, 0);
    repeat (4) drive(0, 0, 1);
    idle(3);
    check("t1_err_underflow", err_underflow, m_und);

    // Extreme left and right shifts.
    drive(1, 0, 0);
    drive(1, 20, 0);
    const_din(-1024, -1024);
    repeat (8) drive(0, 0, 1);
    idle(3);
    check("t2_err_underflow", err_underflow, m_und);

    // Empty queue: unity gain; a scale pushed mid-block waits for the next.
    rand_din(); drive(0, 0, 1);
    check("t3_underflow_set", err_underflow, 1);
    rand_din(); drive(0, 0, 1);
    rand_din(); drive(1, 14, 1);
    rand_din(); drive(0, 0, 1);
    block_rand(1);
    idle(3);
    check("t3_underflow_sticky", err_underflow, m_und);
    do_clr();
    check("t3_clr_underflow", err_underflow, 0);
    check("t3_clr_ready", scale_ready, 1);

    // Overflow and push-with-pop while full.
    for (int i = 0; i < 8; i++) drive(1, pushes_a[i], 0);
    check("t4_ready_full", scale_ready, 0);
    check("t4_no_overflow_yet", err_overflow, 0);
    drive(1, pushes_a[8], 0);
    check("t4_overflow", err_overflow, m_ovf);
    do_clr();
    check("t4_clr_overflow", err_overflow, 0);
    check("t4_clr_ready", scale_ready, 1);
    for (int i = 0; i < 8; i++) drive(1, pushes_b[i], 0);
    check("t4_ready_refull", scale_ready, 0);
    for (int k = 0; k < 3; k++) begin
      rand_din(); drive(0, 0, 1);
    end
    rand_din(); drive(1, 9, 1);
    check("t4_pushpop_ready", scale_ready, 0);
    check("t4_pushpop_no_ovf", err_overflow, m_ovf);
    block_rand(8);
    idle(3);
    check("t4_drained_ready", scale_ready, 1);
    check("t4_drained_underflow", err_underflow, m_und);

    // Gapped block: the scale leaves only on the fourth beat.
    for (int i = 0; i < 8; i++) drive(1, pushes_c[i], 0);
    for (int k = 0; k < 4; k++) begin
      rand_din(); drive(0, 0, 1);
      if (k == 2) begin
        idle(1);
        check("t5_ready_before_last", scale_ready, 0);
      end else if (k < 3) begin
        idle(1);
      end
    end
    check("t5_ready_after_last", scale_ready, 1);
    block_rand(1);
    idle(3);
    do_clr();

    // Asynchronous reset mid-block.
    drive(1, 15, 0);
    for (int k = 0; k < 3; k++) begin
      rand_din(); drive(0, 0, 1);
    end
    #1 rstn = 0;
    #1;
    check("t6_rst_valid_out", valid_out, 0);
    check("t6_rst_dout_R0", dout_R[0], 0);
    check("t6_rst_dout_Q7", dout_Q[7], 0);
    check("t6_rst_ready", scale_ready, 1);
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    rstn = 1;
    drive(1, 8, 0);
    block_rand(1);
    idle(4);
    check("t6_err_underflow", err_underflow, m_und);
    check("t6_ready", scale_ready, 1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
